// File: rtl/fcvt_s_w_if.sv
// Handshake bundle for the integer-to-binary32 converter.
// Optional macro FCVT_FFLAGS_EN adds the out_nx inexact flag.
// master: operand source / result consumer.  slave: the converter.
interface fcvt_s_w_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      rs1;
  logic             is_unsigned;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out;
  logic [TAG_W-1:0] out_tag;
`ifdef FCVT_FFLAGS_EN
  logic             out_nx;

  modport master (
    output in_valid, rs1, is_unsigned, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, out_nx
  );
  modport slave (
    input  in_valid, rs1, is_unsigned, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, out_nx
  );
`else
  modport master (
    output in_valid, rs1, is_unsigned, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag
  );
  modport slave (
    input  in_valid, rs1, is_unsigned, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag
  );
`endif
endinterface

// File: rtl/fcvt_s_w.sv
// FCVT.S.W / FCVT.S.WU: 32-bit integer to IEEE 754 binary32, round to
// nearest even. Three registered stages: sign/magnitude, normalise,
// round/pack. The whole pipe freezes while a result waits on out_ready.
// Optional macro FCVT_FFLAGS_EN adds out_nx (inexact) for fflags.NX.
module fcvt_s_w #(
  parameter int TAG_W = 5
) (
  input logic        clk,
  input logic        resetn,
  fcvt_s_w_if.slave  bus
);

  logic stall;
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // stage 1 combinational: sign and absolute value
  logic        s1_sign;
  logic [31:0] s1_mag;
  assign s1_sign = ~bus.is_unsigned & bus.rs1[31];
  assign s1_mag  = s1_sign ? (~bus.rs1 + 32'd1) : bus.rs1;

  logic             v1;
  logic             sign1;
  logic [31:0]      mag1;
  logic [TAG_W-1:0] tag1;

  // stage 1 register: capture operand as sign/magnitude
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      mag1  <= '0;
      tag1  <= '0;
    end else if (!stall) begin
      v1    <= bus.in_valid;
      sign1 <= s1_sign;
      mag1  <= s1_mag;
      tag1  <= bus.in_tag;
    end
  end

  // leading-zero count; highest set bit wins since the loop runs upward
  logic [4:0] lz;
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag1[i]) lz = 5'(31 - i);
    end
  end

  logic [31:0] s2_norm;
  assign s2_norm = mag1 << lz;

  logic             v2;
  logic             sign2;
  logic [30:0]      norm2;
  logic [7:0]       exp2;
  logic             zero2;
  logic [TAG_W-1:0] tag2;

  // stage 2 register: normalised significand (hidden bit dropped) and exponent
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      norm2 <= '0;
      exp2  <= '0;
      zero2 <= 1'b0;
      tag2  <= '0;
    end else if (!stall) begin
      v2    <= v1;
      sign2 <= sign1;
      norm2 <= s2_norm[30:0];
      exp2  <= 8'd158 - {3'd0, lz};
      zero2 <= (mag1 == 32'd0);
      tag2  <= tag1;
    end
  end

  // stage 3 combinational: RNE rounding; a carry out of the mantissa
  // leaves the field all zeros and bumps the exponent (max 159, never Inf)
  logic [22:0] m;
  logic        g;
  logic        st;
  logic        rnd;
  logic [23:0] m_sum;
  logic [7:0]  exp_r;
  logic [31:0] packed_res;
  assign m          = norm2[30:8];
  assign g          = norm2[7];
  assign st         = |norm2[6:0];
  assign rnd        = g & (st | m[0]);
  assign m_sum      = {1'b0, m} + {23'd0, rnd};
  assign exp_r      = exp2 + {7'd0, m_sum[23]};
  assign packed_res = zero2 ? 32'd0 : {sign2, exp_r, m_sum[22:0]};

  // stage 3 register: result, tag and valid, frozen while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.out_tag   <= '0;
    end else if (!stall) begin
      bus.out_valid <= v2;
      bus.out       <= packed_res;
      bus.out_tag   <= tag2;
    end
  end

`ifdef FCVT_FFLAGS_EN
  // inexact flag travels with the result it describes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.out_nx <= 1'b0;
    end else if (!stall) begin
      bus.out_nx <= g | st;
    end
  end
`endif

endmodule

// File: doc/fcvt_s_w.md
Name: fcvt_s_w

Overview:
- Pipelined integer-to-single-precision converter for RISC-V FCVT.S.W and FCVT.S.WU.
- Takes a 32-bit signed or unsigned integer and produces a correctly rounded IEEE 754 binary32 encoding. This is the encoder direction of the FP datapath.
- Sits beside the FP adder in the FP execute cluster.
- Has a valid/ready handshake on both sides and carries a destination tag through the pipe.

Parameters:
- TAG_W, 5, width of the opaque tag (rd index) carried alongside each operation.

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  operand present this cycle
- in_ready  output  1  block accepts operand when in_valid && in_ready
- rs1  input  32  integer operand
- is_unsigned  input  1  1 = FCVT.S.WU (rs1 unsigned), 0 = FCVT.S.W (two's complement)
- in_tag  input  TAG_W  tag accompanying operand
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result when out_valid && out_ready
- out  output  32  binary32 result {sign, exp[7:0], mant[22:0]}
- out_tag  output  TAG_W  tag of the result

Behaviour:
- Reset: asynchronous, active-low. Clears all stage valid bits, out_valid=0, out=0, out_tag=0 (and the optional flag). In-flight operations are discarded, not completed. First acceptance is possible on the first clk edge after resetn rises.
- Pipeline: 3 registered stages; latency 3 cycles from accept to out_valid when unstalled. Throughput 1 op per cycle.
- S1 (sign/magnitude):
  - sign = ~is_unsigned & rs1[31].
  - mag = sign ? (~rs1 + 1) : rs1, 32-bit unsigned. Signed 0x80000000 gives mag 0x80000000.
- S2 (normalise):
  - lz = leading-zero count of mag (0..31).
  - norm = mag << lz.
  - exp = 158 - lz (bias 127 + 31).
  - zero flag = (mag == 0).
- S3 (round RNE and pack):
  - m = norm[30:8], g = norm[7], s = |norm[6:0].
  - Round up iff g & (s | m[0]).
  - Mantissa carry-out: m becomes 0, exp increments. Max exp is 159, so Inf is never produced.
  - zero gives out=0x00000000; -0 is never produced.
  - No denormals and no NaN are possible.
- Stall: stall = out_valid & ~out_ready.
  - When stall is high, all three stages hold and in_ready=0.
  - Otherwise in_ready=1 and every stage advances. Bubbles advance too; no bubble collapsing.
- in_valid with in_ready=0: the operand is not captured. The source must hold rs1, is_unsigned and in_tag stable until accepted.
- out, out_tag and out_valid hold stable while stalled.
- Simultaneous out handshake and new input in the same cycle are both honoured (full throughput).
- in_tag travels unmodified with its operand; results emerge in issue order.

Optional Feature:
- Macro FCVT_FFLAGS_EN.
- Defined:
  - Adds output out_nx (1 bit) = g | s of the result's operand, registered with out.
  - out_nx reset value is 0 and it holds during stalls.
  - It feeds fflags.NX.
- Undefined: port absent; no flag logic synthesised.

Test Plan:
- Basic values, signed, out_ready=1:
  - rs1=1 -> out=0x3F800000 after exactly 3 cycles.
  - rs1=0xFFFFFFFF -> 0xBF800000.
  - rs1=0 -> 0x00000000.
- Most-negative integer: rs1=0x80000000, is_unsigned=0 -> 0xCF000000.
- Unsigned path:
  - rs1=0xFFFFFFFF, is_unsigned=1 -> 0x4F800000 (carry-out rounding), out_nx=1.
  - rs1=0x80000000, is_unsigned=1 -> 0x4F000000.
- RNE ties:
  - rs1=16777217 -> 0x4B800000 (tie to even, down), out_nx=1.
  - rs1=16777219 -> 0x4B800002 (tie to even, up).
  - rs1=16777216 -> 0x4B800000, out_nx=0.
- Backpressure:
  - Issue 5 back-to-back ops with tags 1..5; hold out_ready=0 for 4 cycles once out_valid rises.
  - Required: in_ready=0 during the hold; out and out_tag stable; all 5 results delivered in order with correct tags and none lost or duplicated.
- Reset mid-flight: assert resetn=0 with 3 ops in flight -> out_valid=0 immediately (asynchronous); after release, no stale results appear.
